// File: rtl/fe_pkg.sv
// Shared types and defaults for the front-end frame scheduler.
// Holds the scheduler state enum and default parameter values.
package fe_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WAIT,
      ST_START,
      ST_RUN,
      ST_DONE
   } fe_state_t;

   localparam int FE_PEND_W_DEF = 3;
   localparam int FE_WDOG_DEF   = 65535;

endpackage

// File: rtl/fe_sched_wdog.sv
// Watchdog counter for the frame scheduler RUN state.
// Ports: clk, reset (async, active-low), clr, en, expire (LIMIT-th enabled cycle).
module fe_sched_wdog
   import fe_pkg::*;
#(
   parameter int LIMIT = FE_WDOG_DEF
) (
   input  logic clk,
   input  logic reset,
   input  logic clr,
   input  logic en,
   output logic expire
);

   localparam int CW = (LIMIT > 1) ? $clog2(LIMIT) : 1;
   localparam logic [CW-1:0] LAST = CW'(LIMIT - 1);

   logic [CW-1:0] cnt;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (en && (cnt != LAST)) begin
         cnt <= cnt + 1'b1;
      end
   end

   // First enabled cycle sees cnt==0, so expire lands on enabled cycle LIMIT.
   assign expire = en && !clr && (cnt == LAST);

endmodule

// File: rtl/fe_sched.sv
// Frame scheduler: starts one feature-core frame per pending speech frame.
// Ports: clk, reset (async, active-low), run, frame_avail, max_frames, fefinish
//        -> fe_start, fe_ready, busy, done, overrun, wdog_err, pend_cnt, frame_cnt.
// Optional RUN watchdog built when FE_SCHED_WDOG_EN is defined.
module fe_sched
   import fe_pkg::*;
#(
   parameter int PEND_W      = FE_PEND_W_DEF,
   parameter int WDOG_CYCLES = FE_WDOG_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              run,
   input  logic              frame_avail,
   input  logic [7:0]        max_frames,
   input  logic              fefinish,
   output logic              fe_start,
   output logic              fe_ready,
   output logic              busy,
   output logic              done,
   output logic              overrun,
   output logic              wdog_err,
   output logic [PEND_W:0]   pend_cnt,
   output logic [7:0]        frame_cnt
);

   localparam logic [PEND_W:0] PEND_MAX = {1'b1, {PEND_W{1'b0}}};

   fe_state_t state;
   fe_state_t state_nxt;

   logic wdog_exp;
   logic pend_full;
   logic pend_inc;
   logic pend_dec;
   logic run_fin;
   logic last_frame;

   assign pend_full  = (pend_cnt == PEND_MAX);
   assign pend_inc   = frame_avail && !pend_full;
   assign pend_dec   = (state == ST_START);
   // A watchdog expiry in the same cycle as fefinish abandons the frame.
   assign run_fin    = (state == ST_RUN) && fefinish && !wdog_exp;
   assign last_frame = (max_frames != 8'd0) &&
                       ((frame_cnt + 8'd1) == max_frames);

`ifdef FE_SCHED_WDOG_EN
   fe_sched_wdog #(
      .LIMIT (WDOG_CYCLES)
   ) u_wdog (
      .clk    (clk),
      .reset  (reset),
      .clr    (state != ST_RUN),
      .en     (state == ST_RUN),
      .expire (wdog_exp)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wdog_err <= 1'b0;
      end else if (wdog_exp) begin
         wdog_err <= 1'b1;
      end
   end
`else
   logic unused_wdog_cycles;

   assign unused_wdog_cycles = ^WDOG_CYCLES;
   assign wdog_exp           = 1'b0;
   assign wdog_err           = 1'b0;
`endif

   // State register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      unique case (state)
         ST_IDLE: begin
            if (run) state_nxt = ST_WAIT;
         end
         ST_WAIT: begin
            if (!run) begin
               state_nxt = ST_IDLE;
            end else if (pend_cnt != '0) begin
               state_nxt = ST_START;
            end
         end
         ST_START: begin
            state_nxt = ST_RUN;
         end
         ST_RUN: begin
            if (wdog_exp) begin
               state_nxt = ST_IDLE;
            end else if (fefinish) begin
               state_nxt = last_frame ? ST_DONE : ST_WAIT;
            end
         end
         ST_DONE: begin
            state_nxt = ST_IDLE;
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   // Outputs decoded from state; all low in IDLE, hence after reset.
   always_comb begin
      fe_start = (state == ST_START);
      fe_ready = (state == ST_START) || (state == ST_RUN);
      busy     = (state != ST_IDLE) && (state != ST_DONE);
      done     = (state == ST_DONE);
   end

   // Pending-frame counter; a frame arriving as one starts nets to zero.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pend_cnt <= '0;
      end else begin
         unique case ({pend_inc, pend_dec})
            2'b10:   pend_cnt <= pend_cnt + 1'b1;
            2'b01:   pend_cnt <= pend_cnt - 1'b1;
            default: pend_cnt <= pend_cnt;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         overrun <= 1'b0;
      end else if (frame_avail && pend_full) begin
         overrun <= 1'b1;
      end
   end

   // Completed-frame counter; wraps naturally at 8 bits.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         frame_cnt <= 8'd0;
      end else if ((state == ST_IDLE) && run) begin
         frame_cnt <= 8'd0;
      end else if (run_fin) begin
         frame_cnt <= frame_cnt + 8'd1;
      end
   end

endmodule
